// File: rtl/egress_reader_pkg.sv
// Switch-wide sizing and shared types for the per-port egress drain engine.
// Imported by egress_reader and its skid FIFO.
package egress_reader_pkg;

    localparam int PORT_NUB_TOTAL = 8;
    localparam int DATA_WIDTH     = 32;
    localparam int LEN_WIDTH      = 8;
    localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HEAD  = 3'd1,
        HWAIT = 3'd2,
        BODY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic                 last;
        logic [WIDTH_SEL-1:0] src;
        logic [DATA_WIDTH-1:0] data;
    } egress_word_t;

endpackage

// File: rtl/egress_skid_fifo.sv
// Two-entry output FIFO: a registered head entry driving the egress port plus
// one skid entry that absorbs a word arriving while the head is stalled.
module egress_skid_fifo
    import egress_reader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  egress_word_t push_word,
    output logic [1:0]   count,
    output logic         head_valid,
    output egress_word_t head_word,
    input  logic         head_ready
);

    logic         head_valid_reg;
    logic         skid_valid_reg;
    egress_word_t head_reg;
    egress_word_t skid_reg;
    logic         pop;

    assign pop        = head_valid_reg & head_ready;
    assign head_valid = head_valid_reg;
    assign head_word  = head_reg;
    assign count      = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};

    // Upstream credit guarantees push never lands on a full FIFO without a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            head_reg       <= '0;
            skid_reg       <= '0;
        end else if (pop) begin
            if (skid_valid_reg) begin
                head_reg <= skid_reg;
                if (push) begin
                    skid_reg <= push_word;
                end else begin
                    skid_valid_reg <= 1'b0;
                end
            end else if (push) begin
                head_reg <= push_word;
            end else begin
                head_valid_reg <= 1'b0;
            end
        end else if (push) begin
            if (!head_valid_reg) begin
                head_reg       <= push_word;
                head_valid_reg <= 1'b1;
            end else begin
                skid_reg       <= push_word;
                skid_valid_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/egress_reader.sv
// Output-port drain engine: round-robin picks a source VOQ with a complete
// package, reads it word by word and streams it out through a skid FIFO.
module egress_reader
    import egress_reader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORT_NUB_TOTAL-1:0] empty_in,
    output logic [WIDTH_SEL-1:0]      rd_sel,
    output logic                      rd_en,
    output logic                      rd_done,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      m_valid,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_last,
    output logic [WIDTH_SEL-1:0]      m_src,
    input  logic                      m_ready
);

    state_t                state_reg, state_next;
    logic [WIDTH_SEL-1:0]  ptr_reg, ptr_next;
    logic [WIDTH_SEL-1:0]  sel_reg, sel_next;
    logic [LEN_WIDTH-1:0]  remain_reg, remain_next;
    logic                  inflight_reg;

    logic [PORT_NUB_TOTAL-1:0] req;
    logic [PORT_NUB_TOTAL-1:0] req_rot;
    logic [WIDTH_SEL-1:0]      offset;
    logic [WIDTH_SEL-1:0]      grant;
    logic [LEN_WIDTH-1:0]      hdr_len;
    logic [1:0]                fifo_count;
    logic [2:0]                occ;
    logic                      pop;
    logic                      credit;
    egress_word_t              push_word;
    egress_word_t              head_word;

    assign req     = ~empty_in;
    assign hdr_len = rd_data[LEN_WIDTH-1:0];

    // Rotate requests so bit 0 is the source at ptr; the lowest set bit wins.
    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUB_TOTAL; gi++) begin : g_rot
            logic [WIDTH_SEL-1:0] idx;
            assign idx         = ptr_reg + WIDTH_SEL'(gi);
            assign req_rot[gi] = req[idx];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int i = PORT_NUB_TOTAL - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = WIDTH_SEL'(i);
            end
        end
    end

    assign grant = ptr_reg + offset;

    // Words already held plus the one still in the VOQ pipeline must leave a slot.
    assign pop    = m_valid & m_ready;
    assign occ    = {1'b0, fifo_count} + {2'b00, inflight_reg};
    assign credit = occ < (3'd2 + {2'b00, pop});

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        sel_next    = sel_reg;
        remain_next = remain_reg;
        rd_en       = 1'b0;
        rd_done     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    sel_next   = grant;
                    ptr_next   = grant + WIDTH_SEL'(1);
                    state_next = HEAD;
                end
            end
            HEAD: begin
                if (credit) begin
                    rd_en      = 1'b1;
                    state_next = HWAIT;
                end
            end
            HWAIT: begin
                remain_next = hdr_len;
                state_next  = (hdr_len == '0) ? DONE : BODY;
            end
            BODY: begin
                // remain hits zero at the final issue; that word is captured now.
                if (remain_reg == '0) begin
                    state_next = DONE;
                end else if (credit) begin
                    rd_en       = 1'b1;
                    remain_next = remain_reg - LEN_WIDTH'(1);
                end
            end
            DONE: begin
                rd_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            sel_reg      <= '0;
            remain_reg   <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            sel_reg      <= sel_next;
            remain_reg   <= remain_next;
            inflight_reg <= rd_en;
        end
    end

    always_comb begin
        push_word.data = rd_data;
        push_word.src  = sel_reg;
        push_word.last = (state_reg == HWAIT) ? (hdr_len == '0) : (remain_reg == '0);
    end

    egress_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_reg),
        .push_word  (push_word),
        .count      (fifo_count),
        .head_valid (m_valid),
        .head_word  (head_word),
        .head_ready (m_ready)
    );

    assign rd_sel = sel_reg;
    assign m_data = head_word.data;
    assign m_last = head_word.last;
    assign m_src  = head_word.src;

endmodule

// File: tb/tb_egress_reader.sv
// Self-checking bench for egress_reader: VOQ emulator, round-robin reference
// model over pending packages, and an egress scoreboard.
module tb_egress_reader;
    import egress_reader_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [PORT_NUB_TOTAL-1:0] empty_in = '1;
    logic [WIDTH_SEL-1:0]      rd_sel;
    logic                      rd_en;
    logic                      rd_done;
    logic [DATA_WIDTH-1:0]     rd_data = '0;
    logic                      m_valid;
    logic [DATA_WIDTH-1:0]     m_data;
    logic                      m_last;
    logic [WIDTH_SEL-1:0]      m_src;
    logic                      m_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    egress_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .empty_in (empty_in),
        .rd_sel   (rd_sel),
        .rd_en    (rd_en),
        .rd_done  (rd_done),
        .rd_data  (rd_data),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_src    (m_src),
        .m_ready  (m_ready)
    );

    // environment: per-source VOQ contents and complete-package counts
    logic [DATA_WIDTH-1:0] voq [PORT_NUB_TOTAL][$];
    int                    env_cnt [PORT_NUB_TOTAL];
    bit                    env_rd_en = 0;
    bit                    env_done = 0;
    int                    env_sel = 0;
    int                    ready_mode = 0;
    int                    ready_phase = 0;
    int                    pat [7] = '{1, 0, 0, 0, 1, 0, 1};
    int                    cyc = 0;

    // reference model: pending packages per source, round-robin pointer
    logic [DATA_WIDTH-1:0] ref_w [PORT_NUB_TOTAL][$];
    int                    ref_n [PORT_NUB_TOTAL][$];
    int                    ref_ptr = 0;
    logic [DATA_WIDTH-1:0] exp_d [$];
    logic                  exp_l [$];
    int                    exp_s [$];
    int                    grant_log [$];

    bit pkt_open = 0;
    int cur_src = 0, cur_len = 0, pkt_rd_cnt = 0, last_rd_cyc = 0;
    int issued = 0, accepted = 0, max_out = 0, done_cnt = 0, rd_en_cnt = 0;
    int mon_g, mon_n;
    bit prev_stall = 0;
    logic [DATA_WIDTH-1:0] prev_data;
    logic prev_last;
    logic [WIDTH_SEL-1:0] prev_src;
    logic [DATA_WIDTH-1:0] ed;
    logic el;
    int es;

    task automatic refresh_empty();
        for (int j = 0; j < PORT_NUB_TOTAL; j++) empty_in[j] = (env_cnt[j] == 0);
    endtask

    task automatic add_pkt(input int src, input int n, output logic [DATA_WIDTH-1:0] hdr);
        logic [DATA_WIDTH-1:0] w;
        hdr = $urandom;
        hdr[LEN_WIDTH-1:0] = LEN_WIDTH'(n);
        voq[src].push_back(hdr);
        ref_w[src].push_back(hdr);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            voq[src].push_back(w);
            ref_w[src].push_back(w);
        end
        ref_n[src].push_back(n);
        env_cnt[src]++;
        refresh_empty();
    endtask

    function automatic int ref_pick();
        for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
            int j;
            j = (ref_ptr + i) % PORT_NUB_TOTAL;
            if (ref_n[j].size() > 0) return j;
        end
        return -1;
    endfunction

    function automatic bit work_left();
        if (exp_d.size() != 0 || pkt_open) return 1;
        for (int j = 0; j < PORT_NUB_TOTAL; j++)
            if (ref_n[j].size() != 0 || env_cnt[j] != 0) return 1;
        return 0;
    endfunction

    // VOQ emulator: read data one cycle after rd_en, count drop on rd_done
    always @(posedge clk) begin
        #1;
        if (env_rd_en && voq[env_sel].size() > 0) rd_data = voq[env_sel].pop_front();
        else rd_data = $urandom;
        if (env_done && env_cnt[env_sel] > 0) env_cnt[env_sel]--;
        refresh_empty();
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       begin m_ready = pat[ready_phase % 7] != 0; ready_phase++; end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        cyc++;
    end

    // monitor: grant prediction, word scoreboard, stall stability, credit bound
    always @(negedge clk) begin
        env_rd_en = 0;
        env_done  = 0;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            env_rd_en = rd_en;
            env_done  = rd_done;
            env_sel   = int'(rd_sel);
            if (prev_stall) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last || m_src !== prev_src) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b s=%0d required v=1 d=%h l=%b s=%0d",
                             m_valid, m_data, m_last, m_src, prev_data, prev_last, prev_src);
                end
            end
            if (m_valid && m_ready) begin
                accepted++;
                total++;
                if (exp_d.size() == 0) begin
                    bad++;
                    $display("FAIL word: got unexpected d=%h l=%b s=%0d required none", m_data, m_last, m_src);
                end else begin
                    ed = exp_d.pop_front(); el = exp_l.pop_front(); es = exp_s.pop_front();
                    if (m_data !== ed || m_last !== el || m_src !== WIDTH_SEL'(es)) begin
                        bad++;
                        $display("FAIL word: got d=%h l=%b s=%0d required d=%h l=%b s=%0d",
                                 m_data, m_last, m_src, ed, el, es);
                    end
                end
            end
            if (rd_en) begin
                if (!pkt_open) begin
                    mon_g = ref_pick();
                    total++;
                    if (mon_g < 0 || rd_sel !== WIDTH_SEL'(mon_g)) begin
                        bad++;
                        $display("FAIL grant: got rd_sel=%0d required %0d", rd_sel, mon_g);
                    end
                    cur_len = 0;
                    if (mon_g >= 0) begin
                        mon_n = ref_n[mon_g].pop_front();
                        for (int i = 0; i <= mon_n; i++) begin
                            exp_d.push_back(ref_w[mon_g].pop_front());
                            exp_l.push_back(i == mon_n);
                            exp_s.push_back(mon_g);
                        end
                        ref_ptr = (mon_g + 1) % PORT_NUB_TOTAL;
                        cur_src = mon_g;
                        cur_len = mon_n + 1;
                        grant_log.push_back(mon_g);
                    end
                    pkt_open = 1;
                    pkt_rd_cnt = 0;
                end
                pkt_rd_cnt++;
                issued++;
                rd_en_cnt++;
                last_rd_cyc = cyc;
                total++;
                if (issued - accepted > 2) begin
                    bad++;
                    $display("FAIL credit: got outstanding=%0d required <=2", issued - accepted);
                end
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (rd_done) begin
                total++;
                done_cnt++;
                if (!pkt_open || rd_sel !== WIDTH_SEL'(cur_src) || pkt_rd_cnt != cur_len) begin
                    bad++;
                    $display("FAIL done: got open=%0b sel=%0d reads=%0d required open=1 sel=%0d reads=%0d",
                             pkt_open, rd_sel, pkt_rd_cnt, cur_src, cur_len);
                end
                if (pkt_open && cur_len == 1) begin
                    total++;
                    if (cyc - last_rd_cyc != 2) begin
                        bad++;
                        $display("FAIL zero_len_gap: got %0d cycles required 2", cyc - last_rd_cyc);
                    end
                end
                pkt_open = 0;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_src   = m_src;
        end
    end

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (work_left() && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        total++;
        if (work_left()) begin
            bad++;
            $display("FAIL drain_timeout: got work pending after %0d cycles required drained", budget);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({rd_sel, rd_en, rd_done, m_valid, m_data, m_last, m_src} !== '0) begin
            bad++;
            $display("FAIL %s: got sel=%0d en=%b done=%b v=%b d=%h l=%b s=%0d required all 0",
                     name, rd_sel, rd_en, rd_done, m_valid, m_data, m_last, m_src);
        end
    endtask

    task automatic clear_all();
        for (int j = 0; j < PORT_NUB_TOTAL; j++) begin
            voq[j].delete(); ref_w[j].delete(); ref_n[j].delete(); env_cnt[j] = 0;
        end
        exp_d.delete(); exp_l.delete(); exp_s.delete();
        pkt_open = 0; ref_ptr = 0; issued = 0; accepted = 0;
        env_rd_en = 0; env_done = 0; prev_stall = 0;
        refresh_empty();
    endtask

    task automatic test_reset();
        logic [DATA_WIDTH-1:0] h;
        rst_n = 1'b0;
        clear_all();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [DATA_WIDTH-1:0] h;
        int base, d0, k;
        int want [4] = '{0, 3, 5, 0};
        base = grant_log.size();
        d0 = done_cnt;
        @(negedge clk); #1;
        add_pkt(0, 1, h); add_pkt(3, 1, h); add_pkt(5, 1, h);
        k = 0;
        while (done_cnt == d0 && k < 50) begin @(negedge clk); #1; k++; end
        add_pkt(0, 1, h);
        wait_drain(200);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (grant_log.size() <= base + i || grant_log[base + i] != want[i]) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %0d required %0d", i,
                         (grant_log.size() > base + i) ? grant_log[base + i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [DATA_WIDTH-1:0] h;
        int d0, r0;
        d0 = done_cnt; r0 = rd_en_cnt;
        @(negedge clk); #1;
        add_pkt(2, 3, h);
        @(negedge clk);
        total++;
        if (rd_en !== 1'b1 || rd_sel !== WIDTH_SEL'(2)) begin
            bad++;
            $display("FAIL hdr_issue: got en=%b sel=%0d required en=1 sel=2", rd_en, rd_sel);
        end
        @(negedge clk);
        total++;
        if (rd_en !== 1'b0) begin
            bad++;
            $display("FAIL hwait_idle: got en=%b required 0", rd_en);
        end
        @(negedge clk);
        total++;
        if (m_valid !== 1'b1 || m_data !== h) begin
            bad++;
            $display("FAIL hdr_latency: got v=%b d=%h required v=1 d=%h", m_valid, m_data, h);
        end
        wait_drain(100);
        total++;
        if (done_cnt - d0 != 1 || rd_en_cnt - r0 != 4) begin
            bad++;
            $display("FAIL single_counts: got done=%0d reads=%0d required done=1 reads=4",
                     done_cnt - d0, rd_en_cnt - r0);
        end
    endtask

    task automatic test_zero_len();
        logic [DATA_WIDTH-1:0] h;
        int r0, a0;
        r0 = rd_en_cnt; a0 = accepted;
        @(negedge clk); #1;
        add_pkt(7, 0, h);
        wait_drain(100);
        total++;
        if (rd_en_cnt - r0 != 1 || accepted - a0 != 1) begin
            bad++;
            $display("FAIL zero_len: got reads=%0d words=%0d required 1 and 1", rd_en_cnt - r0, accepted - a0);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_WIDTH-1:0] h;
        int a0;
        a0 = accepted; max_out = 0;
        ready_mode = 1; ready_phase = 0;
        @(negedge clk); #1;
        add_pkt(1, 6, h);
        wait_drain(300);
        ready_mode = 0;
        total++;
        if (accepted - a0 != 7 || max_out > 2) begin
            bad++;
            $display("FAIL backpressure: got words=%0d max_out=%0d required words=7 max_out<=2",
                     accepted - a0, max_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_WIDTH-1:0] h;
        int k, d0, base;
        @(negedge clk); #1;
        add_pkt(4, 5, h);
        k = 0;
        while (!(pkt_open && pkt_rd_cnt >= 3) && k < 50) begin @(negedge clk); #1; k++; end
        d0 = done_cnt;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_async");
        clear_all();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (done_cnt != d0) begin
            bad++;
            $display("FAIL reset_no_done: got %0d done pulses required 0", done_cnt - d0);
        end
        base = grant_log.size();
        add_pkt(6, 1, h); add_pkt(2, 1, h);
        wait_drain(100);
        total++;
        if (grant_log.size() < base + 2 || grant_log[base] != 2 || grant_log[base + 1] != 6) begin
            bad++;
            $display("FAIL reset_ptr: got first grant %0d required 2 then 6",
                     (grant_log.size() > base) ? grant_log[base] : -1);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({rd_en, rd_done, m_valid} !== 3'b000) begin
                bad++;
                $display("FAIL idle: got en=%b done=%b v=%b required all 0", rd_en, rd_done, m_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [DATA_WIDTH-1:0] h;
        int d0, added;
        for (int r = 0; r < 6; r++) begin
            ready_mode = 2;
            d0 = done_cnt; added = 0;
            @(negedge clk); #1;
            for (int j = 0; j < PORT_NUB_TOTAL; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
                        add_pkt(j, int'($urandom_range(0, 12)), h);
                        added++;
                    end
                end
            end
            wait_drain(3000);
            total++;
            if (done_cnt - d0 != added) begin
                bad++;
                $display("FAIL random_round%0d: got done=%0d required %0d", r, done_cnt - d0, added);
            end
        end
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_len();
        test_backpressure();
        test_reset_mid();
        test_idle();
        test_random();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
